// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver states.
// The TX block is expected to import the same package.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Read-ahead synchronous FIFO: dout always shows the head word.
// A pop on a full FIFO frees room for a push on the same clock.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable framing,
// a receive FIFO and sticky parity/framing/overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DW     = 8,
  parameter int PARITY = 0,
  parameter int STOPB  = 1,
  parameter int OVS    = 16,
  parameter int DEPTH  = 16,
  parameter int DIVW   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic [DIVW-1:0]        div,
  input  logic                   rd,
  output logic [DW-1:0]          dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   clr_err
);

  localparam int PW = $clog2(OVS);
  localparam int BW = $clog2(DW+1);
  localparam logic [PW-1:0] HALF  = PW'(OVS/2-1);
  localparam logic [PW-1:0] FULLT = PW'(OVS-1);

  logic            rs_meta;
  logic            rs;
  logic [DIVW-1:0] tcnt;
  logic            tick;
  rx_state_t       st;
  logic [PW-1:0]   ph;
  logic [BW-1:0]   bcnt;
  logic [DW-1:0]   shreg;
  logic            par_bad;
  logic            stop_bad;
  logic [1:0]      scnt;
  logic            push_q;
  logic [DW-1:0]   word_q;
  logic            perr_q;
  logic            fe_q;
  logic            full;
  logic            empty;
  logic            pop_ok;
  logic            exp_par;

  assign tick    = (tcnt == '0);
  assign valid   = ~empty;
  assign pop_ok  = rd & valid;
  assign exp_par = (PARITY == PARITY_ODD) ? ~(^shreg) : ^shreg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_meta  <= 1'b1;
      rs       <= 1'b1;
      tcnt     <= '0;
      st       <= RX_IDLE;
      ph       <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      scnt     <= '0;
      push_q   <= 1'b0;
      word_q   <= '0;
      perr_q   <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      rs_meta <= rx;
      rs      <= rs_meta;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
      if (st == RX_IDLE && !rs) begin
        // restart the tick phase on the falling start edge
        tcnt     <= '0;
        ph       <= '0;
        bcnt     <= '0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
        scnt     <= '0;
        st       <= RX_START;
      end else begin
        tcnt <= tick ? div : tcnt - 1'b1;
        if (tick) begin
          unique case (st)
            RX_START: begin
              if (ph == HALF) begin
                ph <= '0;
                st <= rs ? RX_IDLE : RX_DATA;
              end else ph <= ph + 1'b1;
            end
            RX_DATA: begin
              if (ph == FULLT) begin
                ph    <= '0;
                shreg <= {rs, shreg[DW-1:1]};
                bcnt  <= bcnt + 1'b1;
                if (bcnt == BW'(DW-1))
                  st <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
              end else ph <= ph + 1'b1;
            end
            RX_PARITY: begin
              if (ph == FULLT) begin
                ph      <= '0;
                par_bad <= (rs != exp_par);
                st      <= RX_STOP;
              end else ph <= ph + 1'b1;
            end
            RX_STOP: begin
              if (ph == FULLT) begin
                ph   <= '0;
                scnt <= scnt + 1'b1;
                if (scnt == 2'(STOPB-1)) begin
                  if (stop_bad || !rs) begin
                    fe_q <= 1'b1;
                    st   <= RX_BREAK;
                  end else begin
                    push_q <= 1'b1;
                    word_q <= shreg;
                    perr_q <= par_bad;
                    st     <= RX_IDLE;
                  end
                end else stop_bad <= stop_bad | ~rs;
              end else ph <= ph + 1'b1;
            end
            RX_BREAK: begin
              if (rs) st <= RX_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // later assignments win so a new error beats clr_err
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (push_q && perr_q && (!full || pop_ok))
        parity_err <= 1'b1;
      if (fe_q)
        frame_err <= 1'b1;
      if (push_q && full && !pop_ok)
        overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (word_q),
    .pop   (rd),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo with a queue-based scoreboard.
// Two instances: 8N1 and 8E1.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int OVS   = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic [15:0] div = 16'd25;
  logic        rd0 = 1'b0;
  logic        rd1 = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  d0, d1;
  logic        v0, v1;
  logic [4:0]  c0, c1;
  logic        pe0, fe0, ov0;
  logic        pe1, fe1, ov1;

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic exp_ovr = 1'b0;
  logic exp_perr1 = 1'b0;
  int lat5 = 0;

  always #124 clk = ~clk;

  uart_rx_fifo #(.PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .div(div),
    .rd(rd0), .dout(d0), .valid(v0), .count(c0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0),
    .clr_err(clr)
  );

  uart_rx_fifo #(.PARITY(2)) u_dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .div(div),
    .rd(rd1), .dout(d1), .valid(v1), .count(c1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1),
    .clr_err(clr)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare head word on every accepted pop
  always @(negedge clk) begin
    if (reset && rd0 && v0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb0_empty: got %0h expected none", d0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (d0 !== e) begin
          failures++;
          $display("FAIL sb0_word: got %0h expected %0h", d0, e);
        end
      end
    end
    if (reset && rd1 && v1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb1_empty: got %0h expected none", d1);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        if (d1 !== e) begin
          failures++;
          $display("FAIL sb1_word: got %0h expected %0h", d1, e);
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input int line, input logic [15:0] bits,
                           input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      if (line == 0) rx0 = bits[i];
      else rx1 = bits[i];
      wclk(bclk);
    end
  endtask

  task automatic accept0(input logic [7:0] d);
    if (q0.size() < DEPTH) q0.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  task automatic frame0(input logic [7:0] d, input int bclk);
    send_bits(0, {6'h3f, 1'b1, d, 1'b0}, 10, bclk);
    rx0 = 1'b1;
    accept0(d);
  endtask

  // frame into an empty FIFO, returning clocks from start edge to valid
  task automatic frame0_meas(input logic [7:0] d, input int bclk,
                             output int lat);
    int n;
    n = 0;
    fork
      send_bits(0, {6'h3f, 1'b1, d, 1'b0}, 10, bclk);
      begin
        while (v0 !== 1'b1 && n < 20000) begin
          wclk(1);
          n++;
        end
      end
    join
    rx0 = 1'b1;
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL lat_timeout: got %0d expected <20000", n);
    end
    accept0(d);
    lat = n;
  endtask

  task automatic frame1(input logic [7:0] d, input logic pbit);
    logic good;
    good = ($countones(d) % 2) == 1;
    send_bits(1, {5'h1f, 1'b1, pbit, d, 1'b0}, 11, 96);
    rx1 = 1'b1;
    if (q1.size() < DEPTH) begin
      q1.push_back(d);
      if (pbit != good) exp_perr1 = 1'b1;
    end
  endtask

  task automatic pop_all(input int line);
    for (int n = 0; n < 40; n++) begin
      if (line == 0) begin
        if (!v0) break;
        rd0 = 1'b1;
        wclk(1);
        rd0 = 1'b0;
      end else begin
        if (!v1) break;
        rd1 = 1'b1;
        wclk(1);
        rd1 = 1'b0;
      end
    end
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    wclk(1);
    clr = 1'b0;
    exp_ovr = 1'b0;
    exp_perr1 = 1'b0;
  endtask

  initial begin
    #(248.0 * 95000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] r;
    logic bad;
    wclk(3);
    chk("rst_valid", v0, 0);
    chk("rst_count", c0, 0);
    chk("rst_dout", d0, 0);
    chk("rst_flags", {pe0, fe0, ov0}, 0);
    reset = 1'b1;
    wclk(4);

    // nominal 8N1 at div=25
    frame0_meas(8'hA5, 16 * 26, lat);
    checks++;
    if (lat < (37 * OVS * 26) / 4 || lat > (39 * OVS * 26) / 4) begin
      failures++;
      $display("FAIL t1_latency: got %0d expected mid stop bit", lat);
    end
    chk("t1_dout", d0, 8'hA5);
    chk("t1_count", c0, 1);
    chk("t1_flags", {pe0, fe0, ov0}, 0);
    pop_all(0);
    chk("t1_empty", v0, 0);

    div = 16'd5;
    wclk(40);

    // overflow with no reads
    frame0_meas(8'h00, 96, lat5);
    for (int i = 1; i < 20; i++) frame0(8'(i), 96);
    chk("t2_count", c0, DEPTH);
    chk("t2_overrun", ov0, exp_ovr);
    pop_all(0);
    chk("t2_valid", v0, 0);
    chk("t2_sb_left", q0.size(), 0);
    pulse_clr();
    chk("t2_clr", ov0, 0);

    // even parity instance
    frame1(8'h03, 1'b1);
    chk("t3_count", c1, 1);
    chk("t3_perr", pe1, exp_perr1);
    pulse_clr();
    chk("t3_clr", pe1, 0);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      bad = 1'($urandom);
      frame1(r, (($countones(r) % 2) == 1) ^ bad);
      chk("t3_rand_perr", pe1, exp_perr1);
      chk("t3_rand_fe", fe1, 0);
    end
    pop_all(1);
    chk("t3_empty", v1, 0);

    // framing error then line break
    send_bits(0, 16'h00AA, 10, 96);
    chk("t4_fe", fe0, 1);
    chk("t4_count", c0, 0);
    wclk(30 * 96);
    chk("t4_break_cnt", c0, 0);
    rx0 = 1'b1;
    wclk(2 * 96);
    frame0(8'h5A, 96);
    chk("t4_dout", d0, 8'h5A);
    pop_all(0);
    pulse_clr();
    chk("t4_clr", fe0, 0);

    // glitch and baud error
    rx0 = 1'b0;
    wclk(2);
    rx0 = 1'b1;
    wclk(20 * 96);
    chk("t5_glitch_cnt", c0, 0);
    chk("t5_glitch_fe", fe0, 0);
    for (int i = 0; i < 6; i++) frame0(8'($urandom), (i % 2) ? 99 : 93);
    chk("t5_count", c0, 6);
    chk("t5_fe", fe0, 0);
    pop_all(0);
    chk("t5_empty", v0, 0);

    // full FIFO with pop landing on the push clock
    for (int i = 0; i < DEPTH; i++) frame0(8'($urandom), 96);
    chk("t6_full", c0, DEPTH);
    r = 8'($urandom);
    fork
      send_bits(0, {6'h3f, 1'b1, r, 1'b0}, 10, 96);
      begin
        wclk(lat5 - 1);
        rd0 = 1'b1;
        wclk(1);
        rd0 = 1'b0;
      end
    join
    rx0 = 1'b1;
    accept0(r);
    chk("t6_count", c0, DEPTH);
    chk("t6_overrun", ov0, exp_ovr);

    // reset mid-frame
    fork
      send_bits(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10, 96);
      begin
        wclk(3 * 96);
        reset = 1'b0;
        wclk(1);
        chk("t6_rst_valid", v0, 0);
        chk("t6_rst_count", c0, 0);
        chk("t6_rst_dout", d0, 0);
        chk("t6_rst_flags", {pe0, fe0, ov0}, 0);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_ovr = 1'b0;
        exp_perr1 = 1'b0;
      end
    join
    rx0 = 1'b1;
    wclk(12 * 96);
    chk("t6_after_cnt", c0, 0);
    chk("t6_after_fe", fe0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
